// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: command sequencer for the up/down counter.
// Accepts one command at a time (optional load, then N enabled count cycles)
// and drives the counter's load/loaddata/en/updwn inputs with registered outputs.
// Optional feature: define CMD_SEQ_PAUSE_EN to add a 'pause' input that stalls
// the RUN phase without losing any of the requested count cycles.
module counter_cmd_seq #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_loaddata,
    input  logic             cmd_updwn,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
`ifdef CMD_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic             load,
    output logic [WIDTH-1:0] loaddata,
    output logic             en,
    output logic             updwn,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [LEN_W-1:0] rem;
    logic [LEN_W-1:0] rem_next;

    logic             accept;
    logic             stall;

    logic             ready_next;
    logic             load_next;
    logic [WIDTH-1:0] loaddata_next;
    logic             en_next;
    logic             updwn_next;
    logic             busy_next;
    logic             done_next;
    logic             aborted_next;

    assign accept = cmd_valid && cmd_ready;

`ifdef CMD_SEQ_PAUSE_EN
    // Pause only matters while counting; it is ignored in every other state.
    assign stall = pause && (state == RUN);
`else
    assign stall = 1'b0;
`endif

    // State register and remaining-cycle counter.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= next_state;
            rem   <= rem_next;
        end
    end

    // Next-state logic. The remaining counter is loaded at the accept edge and
    // only decrements on cycles where en was actually driven high, so a stall
    // never changes the total number of enabled cycles.
    always_comb begin
        next_state = state;
        rem_next   = rem;
        case (state)
            IDLE: begin
                if (accept) begin
                    rem_next = cmd_len;
                    if (cmd_load)
                        next_state = LOAD;
                    else if (cmd_len == '0)
                        next_state = DONE;
                    else
                        next_state = RUN;
                end
            end
            LOAD: begin
                if (abort) begin
                    next_state = IDLE;
                    rem_next   = '0;
                end else if (rem != '0) begin
                    next_state = RUN;
                end else begin
                    next_state = DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                    rem_next   = '0;
                end else if (en) begin
                    rem_next = rem - LEN_W'(1);
                    if (rem == LEN_W'(1))
                        next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                rem_next   = '0;
            end
        endcase
    end

    // Output decode: values are computed from the upcoming state so that the
    // registered outputs line up with the state they describe.
    always_comb begin
        ready_next    = (next_state == IDLE);
        busy_next     = (next_state != IDLE);
        load_next     = (next_state == LOAD);
        en_next       = (next_state == RUN) && !stall;
        done_next     = (next_state == DONE);
        aborted_next  = abort && ((state == LOAD) || (state == RUN));
        loaddata_next = loaddata;
        updwn_next    = updwn;
        if (accept) begin
            updwn_next = cmd_updwn;
            if (cmd_load)
                loaddata_next = cmd_loaddata;
        end
    end

    // Output registers; loaddata and updwn hold their last values while idle.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cmd_ready <= 1'b1;
            load      <= 1'b0;
            loaddata  <= '0;
            en        <= 1'b0;
            updwn     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            cmd_ready <= ready_next;
            load      <= load_next;
            loaddata  <= loaddata_next;
            en        <= en_next;
            updwn     <= updwn_next;
            busy      <= busy_next;
            done      <= done_next;
            aborted   <= aborted_next;
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed testbench for counter_cmd_seq, including a behavioural model of the
// downstream up/down counter driven by the sequencer outputs.
module tb_counter_cmd_seq;

    localparam int WIDTH = 32;
    localparam int LEN_W = 16;

    logic             clk;
    logic             areset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_loaddata;
    logic             cmd_updwn;
    logic [LEN_W-1:0] cmd_len;
    logic             abort;
    logic             pause;
    logic             load;
    logic [WIDTH-1:0] loaddata;
    logic             en;
    logic             updwn;
    logic             busy;
    logic             done;
    logic             aborted;

    int n_checks = 0;
    int n_fail   = 0;

    int en_cyc, load_cyc, done_cyc, abort_cyc, busy_cyc;

    logic [WIDTH-1:0] cnt;

    counter_cmd_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk),
        .areset(areset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_load(cmd_load),
        .cmd_loaddata(cmd_loaddata),
        .cmd_updwn(cmd_updwn),
        .cmd_len(cmd_len),
        .abort(abort),
`ifdef CMD_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .load(load),
        .loaddata(loaddata),
        .en(en),
        .updwn(updwn),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream up/down counter model
    always_ff @(posedge clk or posedge areset) begin
        if (areset)    cnt <= '0;
        else if (load) cnt <= loaddata;
        else if (en)   cnt <= updwn ? cnt + 1 : cnt - 1;
    end

    // Pulse/cycle monitor sampled mid-cycle
    always @(negedge clk) begin
        if (!areset) begin
            if (en)      en_cyc++;
            if (load)    load_cyc++;
            if (done)    done_cyc++;
            if (aborted) abort_cyc++;
            if (busy)    busy_cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        en_cyc = 0; load_cyc = 0; done_cyc = 0; abort_cyc = 0; busy_cyc = 0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
        n_checks++; if ({load, en, busy, done, aborted} !== 5'b00000) begin n_fail++; $display("FAIL rst_ctrl got=%b exp=00000", {load, en, busy, done, aborted}); end
        n_checks++; if (loaddata !== 32'h0) begin n_fail++; $display("FAIL rst_loaddata got=%h exp=0", loaddata); end
        n_checks++; if (updwn !== 1'b1) begin n_fail++; $display("FAIL rst_updwn got=%b exp=1", updwn); end
        step();
        step();
        areset = 1'b0;
        step();
        n_checks++; if ({cmd_ready, busy, en} !== 3'b100) begin n_fail++; $display("FAIL rst_idle got=%b exp=100", {cmd_ready, busy, en}); end
    endtask

    task automatic test_load_count();
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_loaddata = 32'h0000000A; cmd_updwn = 1'b1; cmd_len = 16'd5;
        clear_mon();
        step();
        cmd_valid = 1'b0; cmd_load = 1'b0;
        n_checks++; if ({load, en, busy, cmd_ready} !== 4'b1010) begin n_fail++; $display("FAIL lc_loadcyc got=%b exp=1010", {load, en, busy, cmd_ready}); end
        n_checks++; if (loaddata !== 32'h0000000A) begin n_fail++; $display("FAIL lc_loaddata got=%h exp=0000000a", loaddata); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if ({en, updwn, load} !== 3'b110) begin n_fail++; $display("FAIL lc_en%0d got=%b exp=110", i, {en, updwn, load}); end
        end
        step();
        n_checks++; if ({done, en} !== 2'b10) begin n_fail++; $display("FAIL lc_done got=%b exp=10", {done, en}); end
        n_checks++; if (cnt !== 32'h0000000F) begin n_fail++; $display("FAIL lc_cnt got=%h exp=0000000f", cnt); end
        step();
        n_checks++; if ({done, cmd_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL lc_idle got=%b exp=010", {done, cmd_ready, busy}); end
        n_checks++; if (loaddata !== 32'h0000000A) begin n_fail++; $display("FAIL lc_hold got=%h exp=0000000a", loaddata); end
        n_checks++; if ({load_cyc, en_cyc, done_cyc} !== {32'd1, 32'd5, 32'd1}) begin n_fail++; $display("FAIL lc_mon got=%0d/%0d/%0d exp=1/5/1", load_cyc, en_cyc, done_cyc); end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_updwn = 1'b0; cmd_len = 16'd3;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
        clear_mon();
        step();
        cmd_valid = 1'b0;
        n_checks++; if ({en, updwn, busy, cmd_ready} !== 4'b1010) begin n_fail++; $display("FAIL b2b_first got=%b exp=1010", {en, updwn, busy, cmd_ready}); end
        step();
        step();
        n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL b2b_en3 got=%b exp=1", en); end
        step();
        n_checks++; if ({done, en} !== 2'b10) begin n_fail++; $display("FAIL b2b_done got=%b exp=10", {done, en}); end
        n_checks++; if (cnt !== 32'h0000000C) begin n_fail++; $display("FAIL b2b_cnt got=%h exp=0000000c", cnt); end
        step();
        n_checks++; if ({done, cmd_ready, updwn} !== 3'b010) begin n_fail++; $display("FAIL b2b_idle got=%b exp=010", {done, cmd_ready, updwn}); end
        n_checks++; if ({en_cyc, done_cyc} !== {32'd3, 32'd1}) begin n_fail++; $display("FAIL b2b_mon got=%0d/%0d exp=3/1", en_cyc, done_cyc); end
    endtask

    task automatic test_valid_held();
        logic [3:0] exp_tab [5];
        exp_tab[0] = 4'b1100; exp_tab[1] = 4'b0101; exp_tab[2] = 4'b0010;
        exp_tab[3] = 4'b1100; exp_tab[4] = 4'b0101;
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_updwn = 1'b1; cmd_len = 16'd1;
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 3) cmd_valid = 1'b0;
            n_checks++; if ({en, busy, cmd_ready, done} !== exp_tab[i]) begin n_fail++; $display("FAIL held_c%0d got=%b exp=%b", i, {en, busy, cmd_ready, done}, exp_tab[i]); end
        end
        step();
        n_checks++; if (en_cyc !== 2) begin n_fail++; $display("FAIL held_en got=%0d exp=2", en_cyc); end
        n_checks++; if (cnt !== 32'h0000000E) begin n_fail++; $display("FAIL held_cnt got=%h exp=0000000e", cnt); end
    endtask

    task automatic test_zero_len();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_updwn = 1'b1; cmd_len = 16'd0;
        clear_mon();
        step();
        cmd_valid = 1'b0;
        n_checks++; if ({done, busy, en, load} !== 4'b1100) begin n_fail++; $display("FAIL z_done got=%b exp=1100", {done, busy, en, load}); end
        step();
        n_checks++; if ({done, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL z_idle got=%b exp=001", {done, busy, cmd_ready}); end
        n_checks++; if ({busy_cyc, en_cyc, load_cyc} !== {32'd1, 32'd0, 32'd0}) begin n_fail++; $display("FAIL z_mon got=%0d/%0d/%0d exp=1/0/0", busy_cyc, en_cyc, load_cyc); end
    endtask

    task automatic test_zero_len_load();
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_loaddata = 32'h00000055; cmd_updwn = 1'b1; cmd_len = 16'd0;
        clear_mon();
        step();
        cmd_valid = 1'b0; cmd_load = 1'b0;
        n_checks++; if ({load, en, busy} !== 3'b101) begin n_fail++; $display("FAIL zl_load got=%b exp=101", {load, en, busy}); end
        step();
        n_checks++; if ({done, en, load} !== 3'b100) begin n_fail++; $display("FAIL zl_done got=%b exp=100", {done, en, load}); end
        step();
        n_checks++; if (cnt !== 32'h00000055) begin n_fail++; $display("FAIL zl_cnt got=%h exp=00000055", cnt); end
        n_checks++; if ({busy, en_cyc} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL zl_end got=%b/%0d exp=0/0", busy, en_cyc); end
    endtask

    task automatic test_abort();
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_loaddata = 32'h000000FF; cmd_updwn = 1'b1; cmd_len = 16'd10;
        clear_mon();
        step();
        cmd_valid = 1'b0; cmd_load = 1'b0;
        n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL ab_load got=%b exp=1", load); end
        step();
        step();
        n_checks++; if (en !== 1'b1) begin n_fail++; $display("FAIL ab_en2 got=%b exp=1", en); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if ({en, load, aborted, done, busy, cmd_ready} !== 6'b001001) begin n_fail++; $display("FAIL ab_edge got=%b exp=001001", {en, load, aborted, done, busy, cmd_ready}); end
        n_checks++; if (cnt !== 32'h00000101) begin n_fail++; $display("FAIL ab_cnt got=%h exp=00000101", cnt); end
        step();
        n_checks++; if (aborted !== 1'b0) begin n_fail++; $display("FAIL ab_pulse got=%b exp=0", aborted); end
        step();
        step();
        n_checks++; if ({done_cyc, abort_cyc, en_cyc} !== {32'd0, 32'd1, 32'd2}) begin n_fail++; $display("FAIL ab_mon got=%0d/%0d/%0d exp=0/1/2", done_cyc, abort_cyc, en_cyc); end
    endtask

    task automatic test_abort_ignored();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_updwn = 1'b1; cmd_len = 16'd2; abort = 1'b1;
        clear_mon();
        step();
        cmd_valid = 1'b0; abort = 1'b0;
        n_checks++; if ({en, busy, aborted} !== 3'b110) begin n_fail++; $display("FAIL ai_idle got=%b exp=110", {en, busy, aborted}); end
        step();
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ai_done got=%b exp=1", done); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if ({aborted, cmd_ready, done} !== 3'b010) begin n_fail++; $display("FAIL ai_donest got=%b exp=010", {aborted, cmd_ready, done}); end
        n_checks++; if ({en_cyc, abort_cyc} !== {32'd2, 32'd0}) begin n_fail++; $display("FAIL ai_mon got=%0d/%0d exp=2/0", en_cyc, abort_cyc); end
        n_checks++; if (cnt !== 32'h00000103) begin n_fail++; $display("FAIL ai_cnt got=%h exp=00000103", cnt); end
    endtask

    task automatic test_areset_mid_run();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_updwn = 1'b0; cmd_len = 16'd20;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        n_checks++; if ({en, updwn} !== 2'b10) begin n_fail++; $display("FAIL ar_run got=%b exp=10", {en, updwn}); end
        #2;
        areset = 1'b1;
        #1;
        n_checks++; if ({en, busy, updwn, load, done, aborted, cmd_ready} !== 7'b0010001) begin n_fail++; $display("FAIL ar_async got=%b exp=0010001", {en, busy, updwn, load, done, aborted, cmd_ready}); end
        n_checks++; if (loaddata !== 32'h0) begin n_fail++; $display("FAIL ar_loaddata got=%h exp=0", loaddata); end
        step();
        areset = 1'b0;
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_loaddata = 32'h00000003; cmd_updwn = 1'b1; cmd_len = 16'd2;
        clear_mon();
        step();
        cmd_valid = 1'b0; cmd_load = 1'b0;
        n_checks++; if ({load, busy} !== 2'b11) begin n_fail++; $display("FAIL ar_reload got=%b exp=11", {load, busy}); end
        step(); step(); step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ar_done got=%b exp=1", done); end
        n_checks++; if (cnt !== 32'h00000005) begin n_fail++; $display("FAIL ar_cnt got=%h exp=00000005", cnt); end
        step();
        n_checks++; if ({en_cyc, done_cyc, abort_cyc} !== {32'd2, 32'd1, 32'd0}) begin n_fail++; $display("FAIL ar_mon got=%0d/%0d/%0d exp=2/1/0", en_cyc, done_cyc, abort_cyc); end
    endtask

    task automatic test_max_len();
        int bad;
        bad = 0;
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_loaddata = 32'h0; cmd_updwn = 1'b1; cmd_len = 16'hFFFF;
        clear_mon();
        step();
        cmd_valid = 1'b0; cmd_load = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            step();
            if (en !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL max_en_gaps got=%0d exp=0", bad); end
        step();
        n_checks++; if ({done, en} !== 2'b10) begin n_fail++; $display("FAIL max_done got=%b exp=10", {done, en}); end
        n_checks++; if (cnt !== 32'h0000FFFF) begin n_fail++; $display("FAIL max_cnt got=%h exp=0000ffff", cnt); end
        step();
        n_checks++; if (en_cyc !== 65535) begin n_fail++; $display("FAIL max_mon got=%0d exp=65535", en_cyc); end
    endtask

`ifdef CMD_SEQ_PAUSE_EN
    task automatic test_pause();
        logic [1:0]       exp_tab [10];
        logic [WIDTH-1:0] base;
        exp_tab[0] = 2'b10; exp_tab[1] = 2'b10; exp_tab[2] = 2'b00; exp_tab[3] = 2'b00; exp_tab[4] = 2'b00;
        exp_tab[5] = 2'b10; exp_tab[6] = 2'b10; exp_tab[7] = 2'b10; exp_tab[8] = 2'b10; exp_tab[9] = 2'b01;
        base = cnt;
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_updwn = 1'b1; cmd_len = 16'd6;
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            step();
            cmd_valid = 1'b0;
            if (i == 1) pause = 1'b1;
            if (i == 4) pause = 1'b0;
            n_checks++; if ({en, done} !== exp_tab[i]) begin n_fail++; $display("FAIL pause_c%0d got=%b exp=%b", i, {en, done}, exp_tab[i]); end
        end
        step();
        n_checks++; if (cnt !== base + 6) begin n_fail++; $display("FAIL pause_cnt got=%h exp=%h", cnt, base + 6); end
        n_checks++; if (en_cyc !== 6) begin n_fail++; $display("FAIL pause_mon got=%0d exp=6", en_cyc); end
    endtask
`endif

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_loaddata = '0;
        cmd_updwn = 1'b0; cmd_len = '0; abort = 1'b0; pause = 1'b0;
        clear_mon();
        test_reset();
        test_load_count();
        test_back_to_back();
        test_valid_held();
        test_zero_len();
        test_zero_len_load();
        test_abort();
        test_abort_ignored();
        test_areset_mid_run();
        test_max_len();
`ifdef CMD_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
Command sequencer that sits directly upstream of the up/down counter and drives its load, loaddata, en and updwn inputs. It accepts one command at a time over a valid/ready handshake. Each command is: optional load of a start value, then exactly N enabled count cycles in a chosen direction. It reports busy, a done pulse and an aborted pulse to the controlling logic.

Parameters:
WIDTH, 32, width of the load value; matches the counter data width
LEN_W, 16, width of the count-length field; up to 2^LEN_W-1 enabled cycles per command

Ports:
clk  input  1  system clock, rising edge
areset  input  1  asynchronous reset, active-high; all flops clear on assertion
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_load  input  1  1 = issue a load before counting
cmd_loaddata  input  WIDTH  value to load
cmd_updwn  input  1  count direction: 1 = up, 0 = down
cmd_len  input  LEN_W  number of cycles with en asserted
abort  input  1  synchronous abort of the command in progress
load  output  1  to counter load
loaddata  output  WIDTH  to counter loaddata
en  output  1  to counter en
updwn  output  1  to counter updwn
busy  output  1  a command is in progress
done  output  1  one-cycle pulse on normal completion
aborted  output  1  one-cycle pulse on abort

Behaviour:
- Interface: one clock (clk); reset areset is asynchronous and active-high.
- All outputs are registered. Reset values:
  - cmd_ready=1, load=0, loaddata=0, en=0, updwn=1, busy=0, done=0, aborted=0.
  - FSM goes to IDLE; the remaining-cycle counter clears to 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - A command is accepted on a cycle where cmd_valid && cmd_ready; all cmd_* fields are captured at that edge.
  - Next state: LOAD if cmd_load; else DONE if cmd_len==0; else RUN.
  - cmd_ready is 0 in every other state.
- LOAD:
  - load=1 for exactly one cycle, with loaddata = captured value.
  - Next state: RUN if len!=0, else DONE.
- RUN:
  - en=1 and updwn = captured direction.
  - The remaining counter starts at cmd_len and decrements on each en cycle.
  - en is high for exactly cmd_len consecutive cycles, then the FSM goes to DONE.
- DONE:
  - done=1 for one cycle, en=0, then back to IDLE.
  - A new command can be accepted in the cycle after done.
- Latency: accept edge at cycle N.
  - With load: load high in cycle N+1, en in cycles N+2 … N+1+len, done in cycle N+2+len.
  - Without load: en starts at N+1.
- loaddata holds its last value after load deasserts.
- updwn holds the last commanded direction while idle.
- busy = (state != IDLE).
- Boundary conditions:
  - cmd_len==0 with cmd_load=0: done in cycle N+1; en and load never assert.
  - cmd_len==0 with cmd_load=1: load pulse, then done; no en.
  - cmd_len = max value (2^LEN_W-1): full length runs with no wrap of the remaining counter.
  - abort in LOAD or RUN: at the next edge load=0, en=0, aborted=1 for one cycle, state goes to IDLE, and done does not pulse.
  - abort in IDLE or DONE: ignored. A command presented together with abort in IDLE is still accepted.
  - areset mid-operation: outputs go to reset values immediately (asynchronously); the in-flight command is lost with no done or aborted pulse.
  - cmd_valid held high while busy: the command is not consumed until the FSM returns to IDLE.

Optional Feature:
- Macro CMD_SEQ_PAUSE_EN adds input port pause (1 bit).
- With the macro defined: while pause=1 in RUN, en=0, the remaining counter holds, and the FSM stays in RUN. When pause deasserts, en resumes; the total en-cycle count still equals cmd_len. pause has no effect in other states, and abort overrides pause.
- Without the macro: no pause port, and RUN is never stalled.

Test Plan:
- Reset, then command load=1, loaddata=0x0000000A, updwn=1, len=5 -> load high for 1 cycle with loaddata=0x0A; en high for 5 cycles; done pulse; a downstream counter reads 0x0000000F.
- Next command load=0, updwn=0, len=3 issued right after done -> cmd_ready=1 only in IDLE; en high for 3 cycles with updwn=0; counter reads 0x0000000C; single done pulse.
- Command load=0, len=0 -> done in cycle N+1; en and load stay 0; busy high for exactly 1 cycle.
- Command load=1, loaddata=0xFF, len=10, abort asserted after 2 en cycles -> en low at the next edge; aborted pulses once, done never; counter reads 0x101; FSM idle.
- areset asserted mid-RUN (len=20, after 4 en cycles) -> en=0, busy=0, updwn=1, loaddata=0 without waiting for a clock edge; a subsequent command runs normally.
- With CMD_SEQ_PAUSE_EN defined: len=6, pause high for 3 cycles after the 2nd en cycle -> exactly 6 en cycles in total, done delayed by 3 cycles.
